// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Two-master, one-slave bus arbiter. Master 0 (CPU) and master 1 (HPS bridge)
//   issue held read/write requests; the arbiter grants one at a time
//   (round-robin), forwards the registered request to the shared slave, waits
//   for the slave acknowledge (or a wait-cycle timeout) and returns a one-cycle
//   acknowledge with read data to the granted master.
//
// Parameters
//   TIMEOUT   slave wait-cycle limit before the transfer is aborted (1..65535)
//   ERR_DATA  read data returned to the master on an aborted transfer
//
// Ports
//   clock, reset                 system clock (rising edge), async active-high reset
//   mN_address/byte_enable       master N request address and byte lanes
//   mN_read/mN_write             master N request, held until mN_acknowledge
//   mN_write_data                master N write data
//   mN_acknowledge               one-cycle completion pulse to master N
//   mN_read_data                 read data, valid while mN_acknowledge=1
//   s_*                          shared slave request / response
//   grant                        one-hot owner: 01=m0, 10=m1, 00=none
//   timeout_error                sticky abort flag, cleared only by reset
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int unsigned  TIMEOUT  = 255,
    parameter logic [31:0]  ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [23:0] m0_address,
    input  logic [3:0]  m0_byte_enable,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_write_data,
    output logic        m0_acknowledge,
    output logic [31:0] m0_read_data,

    input  logic [23:0] m1_address,
    input  logic [3:0]  m1_byte_enable,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_write_data,
    output logic        m1_acknowledge,
    output logic [31:0] m1_read_data,

    output logic [23:0] s_address,
    output logic [3:0]  s_byte_enable,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_write_data,
    input  logic        s_acknowledge,
    input  logic [31:0] s_read_data,

    output logic [1:0]  grant,
    output logic        timeout_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // r_owner is the master granted most recently; it doubles as the
    // round-robin pointer. Resetting it to m1 gives m0 priority after reset.
    logic        r_owner;
    // Set for the single IDLE cycle that follows RESP so that the master just
    // acknowledged cannot be re-granted on a still-held request.
    logic        r_skip;
    logic        r_is_write;
    logic        r_timeout_error;
    logic [23:0] r_address;
    logic [3:0]  r_byte_enable;
    logic [31:0] r_write_data;
    logic [31:0] r_read_data;
    logic [15:0] r_wait;

    logic        w_m0_cand;
    logic        w_m1_cand;
    logic        w_grant_en;
    logic        w_grant_id;
    logic        w_timeout;
    logic        w_busy;
    logic        w_resp;
    logic [16:0] w_wait_inc;

    assign w_m0_cand = (m0_read | m0_write) & ~(r_skip & ~r_owner);
    assign w_m1_cand = (m1_read | m1_write) & ~(r_skip &  r_owner);

    // Abort when this BUSY cycle would bring the wait count up to TIMEOUT.
    // A slave acknowledge in that same cycle takes precedence (checked first).
    assign w_wait_inc = {1'b0, r_wait} + 17'd1;
    assign w_timeout  = (w_wait_inc >= 17'(TIMEOUT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_en   = 1'b0;
        w_grant_id   = r_owner;
        case (r_state)
            IDLE: begin
                if (w_m0_cand && w_m1_cand) begin
                    w_grant_en = 1'b1;
                    w_grant_id = ~r_owner;
                end else if (w_m0_cand) begin
                    w_grant_en = 1'b1;
                    w_grant_id = 1'b0;
                end else if (w_m1_cand) begin
                    w_grant_en = 1'b1;
                    w_grant_id = 1'b1;
                end
                if (w_grant_en) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (s_acknowledge || w_timeout) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_owner         <= 1'b1;
            r_skip          <= 1'b0;
            r_is_write      <= 1'b0;
            r_timeout_error <= 1'b0;
            r_address       <= '0;
            r_byte_enable   <= '0;
            r_write_data    <= '0;
            r_read_data     <= '0;
            r_wait          <= '0;
        end else begin
            r_skip <= (r_state == RESP);
            if (w_grant_en) begin
                r_owner       <= w_grant_id;
                r_address     <= w_grant_id ? m1_address     : m0_address;
                r_byte_enable <= w_grant_id ? m1_byte_enable : m0_byte_enable;
                r_write_data  <= w_grant_id ? m1_write_data  : m0_write_data;
                // read=write=1 is treated as a write
                r_is_write    <= w_grant_id ? m1_write       : m0_write;
                r_wait        <= '0;
            end
            if (r_state == BUSY) begin
                if (s_acknowledge) begin
                    r_read_data <= s_read_data;
                end else if (w_timeout) begin
                    r_read_data     <= ERR_DATA;
                    r_timeout_error <= 1'b1;
                end else begin
                    r_wait <= w_wait_inc[15:0];
                end
            end
        end
    end

    assign w_busy = (r_state == BUSY);
    assign w_resp = (r_state == RESP);

    // Slave side is driven only while BUSY; leaving BUSY (ack or abort)
    // drops s_read/s_write on the next cycle.
    assign s_address     = w_busy ? r_address     : '0;
    assign s_byte_enable = w_busy ? r_byte_enable : '0;
    assign s_write_data  = w_busy ? r_write_data  : '0;
    assign s_read        = w_busy & ~r_is_write;
    assign s_write       = w_busy &  r_is_write;

    assign m0_acknowledge = w_resp & ~r_owner;
    assign m1_acknowledge = w_resp &  r_owner;
    assign m0_read_data   = m0_acknowledge ? r_read_data : '0;
    assign m1_read_data   = m1_acknowledge ? r_read_data : '0;

    assign grant         = (r_state == IDLE) ? 2'b00 : (r_owner ? 2'b10 : 2'b01);
    assign timeout_error = r_timeout_error;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed self-checking bench for bus_arbiter (TIMEOUT=4). A small slave
//   model acknowledges slave_lat cycles after it first sees a request
//   (slave_lat=0: never acknowledges).
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    logic        clock;
    logic        reset;
    logic [23:0] m0_address;
    logic [3:0]  m0_byte_enable;
    logic        m0_read;
    logic        m0_write;
    logic [31:0] m0_write_data;
    logic        m0_acknowledge;
    logic [31:0] m0_read_data;
    logic [23:0] m1_address;
    logic [3:0]  m1_byte_enable;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_write_data;
    logic        m1_acknowledge;
    logic [31:0] m1_read_data;
    logic [23:0] s_address;
    logic [3:0]  s_byte_enable;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_write_data;
    logic        s_acknowledge;
    logic [31:0] s_read_data;
    logic [1:0]  grant;
    logic        timeout_error;

    int          n_checks = 0;
    int          n_errors = 0;
    int          slave_lat;
    int          slave_cnt;
    logic [31:0] slave_data;

    // {grant, m1_acknowledge, m0_acknowledge} per cycle for two held writers
    localparam logic [3:0] T2_EXP [16] = '{
        4'b0000, 4'b0100, 4'b0100, 4'b0101,
        4'b0000, 4'b1000, 4'b1000, 4'b1010,
        4'b0000, 4'b0100, 4'b0100, 4'b0101,
        4'b0000, 4'b1000, 4'b1000, 4'b1010
    };

    bus_arbiter #(
        .TIMEOUT  (4),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .m0_address     (m0_address),
        .m0_byte_enable (m0_byte_enable),
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_write_data  (m0_write_data),
        .m0_acknowledge (m0_acknowledge),
        .m0_read_data   (m0_read_data),
        .m1_address     (m1_address),
        .m1_byte_enable (m1_byte_enable),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_write_data  (m1_write_data),
        .m1_acknowledge (m1_acknowledge),
        .m1_read_data   (m1_read_data),
        .s_address      (s_address),
        .s_byte_enable  (s_byte_enable),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_write_data   (s_write_data),
        .s_acknowledge  (s_acknowledge),
        .s_read_data    (s_read_data),
        .grant          (grant),
        .timeout_error  (timeout_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Slave model: one-cycle ack pulse after slave_lat request cycles.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            s_acknowledge <= 1'b0;
            slave_cnt     <= 0;
        end else if ((s_read || s_write) && !s_acknowledge && slave_lat != 0) begin
            if (slave_cnt + 1 == slave_lat) begin
                s_acknowledge <= 1'b1;
                slave_cnt     <= 0;
            end else begin
                slave_cnt <= slave_cnt + 1;
            end
        end else begin
            s_acknowledge <= 1'b0;
            if (!(s_read || s_write)) slave_cnt <= 0;
        end
    end

    assign s_read_data = s_acknowledge ? slave_data : 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " grant"}, 32'(grant), 0);
        check_eq({tag, " s_read"}, 32'(s_read), 0);
        check_eq({tag, " s_write"}, 32'(s_write), 0);
        check_eq({tag, " s_address"}, 32'(s_address), 0);
        check_eq({tag, " m0_ack"}, 32'(m0_acknowledge), 0);
        check_eq({tag, " m1_ack"}, 32'(m1_acknowledge), 0);
        check_eq({tag, " timeout_error"}, 32'(timeout_error), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100us");
        $fatal(1);
    end

    initial begin
        int acks;
        reset          = 1'b1;
        m0_address     = '0;
        m0_byte_enable = '0;
        m0_read        = 1'b0;
        m0_write       = 1'b0;
        m0_write_data  = '0;
        m1_address     = '0;
        m1_byte_enable = '0;
        m1_read        = 1'b0;
        m1_write       = 1'b0;
        m1_write_data  = '0;
        slave_lat      = 0;
        slave_data     = '0;

        tick();
        tick();
        check_all_zero("reset");
        check_eq("reset m0_read_data", m0_read_data, 0);
        reset = 1'b0;
        tick();
        tick();

        // Single m0 read, one-cycle slave
        slave_lat      = 1;
        slave_data     = 32'h12345678;
        m0_address     = 24'h000100;
        m0_byte_enable = 4'hF;
        m0_read        = 1'b1;
        check_eq("t1 c0 s_read", 32'(s_read), 0);
        tick();
        check_eq("t1 c1 s_read", 32'(s_read), 1);
        check_eq("t1 c1 grant", 32'(grant), 1);
        check_eq("t1 c1 s_address", 32'(s_address), 32'h100);
        check_eq("t1 c1 m0_ack", 32'(m0_acknowledge), 0);
        tick();
        check_eq("t1 c2 grant", 32'(grant), 1);
        check_eq("t1 c2 m0_ack", 32'(m0_acknowledge), 0);
        tick();
        check_eq("t1 c3 m0_ack", 32'(m0_acknowledge), 1);
        check_eq("t1 c3 m0_read_data", m0_read_data, 32'h12345678);
        check_eq("t1 c3 m1_ack", 32'(m1_acknowledge), 0);
        m0_read = 1'b0;
        tick();
        check_eq("t1 c4 grant", 32'(grant), 0);
        check_eq("t1 c4 m0_ack", 32'(m0_acknowledge), 0);

        // Both masters write, held: m0, m1, m0, m1 from reset priority
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        m0_write      = 1'b1;
        m0_address    = 24'h000200;
        m0_write_data = 32'hA0A0A0A0;
        m1_write      = 1'b1;
        m1_address    = 24'h000300;
        m1_byte_enable = 4'hF;
        m1_write_data = 32'hB1B1B1B1;
        for (int c = 0; c < 16; c++) begin
            check_eq($sformatf("t2 c%0d grant/ack", c),
                     32'({grant, m1_acknowledge, m0_acknowledge}), 32'(T2_EXP[c]));
            if (c == 1) begin
                check_eq("t2 c1 s_write", 32'(s_write), 1);
                check_eq("t2 c1 s_address", 32'(s_address), 32'h200);
                check_eq("t2 c1 s_write_data", s_write_data, 32'hA0A0A0A0);
            end
            if (c == 5) begin
                check_eq("t2 c5 s_address", 32'(s_address), 32'h300);
                check_eq("t2 c5 s_write_data", s_write_data, 32'hB1B1B1B1);
            end
            if (c == 15) begin
                m0_write = 1'b0;
                m1_write = 1'b0;
            end
            tick();
        end
        check_eq("t2 c16 grant", 32'(grant), 0);
        tick();

        // m1 read, slave never acknowledges -> abort after 4 wait cycles
        slave_lat  = 0;
        m1_address = 24'h000400;
        m1_read    = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_eq($sformatf("t3 c%0d s_read", c), 32'(s_read), 1);
            check_eq($sformatf("t3 c%0d timeout_error", c), 32'(timeout_error), 0);
        end
        tick();
        check_eq("t3 c5 s_read", 32'(s_read), 0);
        check_eq("t3 c5 m1_ack", 32'(m1_acknowledge), 1);
        check_eq("t3 c5 m1_read_data", m1_read_data, 32'hDEADBEEF);
        check_eq("t3 c5 timeout_error", 32'(timeout_error), 1);
        m1_read = 1'b0;
        tick();
        check_eq("t3 c6 m1_ack", 32'(m1_acknowledge), 0);
        repeat (3) tick();
        check_eq("t3 sticky timeout_error", 32'(timeout_error), 1);
        check_eq("t3 idle grant", 32'(grant), 0);

        // Ack in the same cycle the wait count reaches TIMEOUT wins
        reset = 1'b1;
        #1;
        check_eq("t4 reset timeout_error", 32'(timeout_error), 0);
        tick();
        reset      = 1'b0;
        slave_lat  = 3;
        slave_data = 32'hCAFEF00D;
        m1_address = 24'h000500;
        m1_read    = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_eq($sformatf("t4 c%0d s_read", c), 32'(s_read), 1);
        end
        check_eq("t4 c4 timeout_error", 32'(timeout_error), 0);
        tick();
        check_eq("t4 c5 m1_ack", 32'(m1_acknowledge), 1);
        check_eq("t4 c5 m1_read_data", m1_read_data, 32'hCAFEF00D);
        check_eq("t4 c5 timeout_error", 32'(timeout_error), 0);
        m1_read = 1'b0;
        tick();
        check_eq("t4 c6 m1_ack", 32'(m1_acknowledge), 0);
        check_eq("t4 c6 timeout_error", 32'(timeout_error), 0);

        // Reset pulsed mid-transfer
        slave_lat  = 0;
        m0_address = 24'h000600;
        m0_read    = 1'b1;
        tick();
        check_eq("t5 c1 grant", 32'(grant), 1);
        check_eq("t5 c1 s_read", 32'(s_read), 1);
        tick();
        reset = 1'b1;
        #1;
        check_all_zero("t5 in reset");
        m0_read   = 1'b0;
        slave_lat = 1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq($sformatf("t5 post c%0d grant/ack", c),
                     32'({grant, m1_acknowledge, m0_acknowledge}), 0);
        end
        slave_data = 32'h0BADF00D;
        m1_address = 24'h000700;
        m1_read    = 1'b1;
        check_eq("t5 m1 c0 grant", 32'(grant), 0);
        tick();
        check_eq("t5 m1 c1 grant", 32'(grant), 2);
        check_eq("t5 m1 c1 s_read", 32'(s_read), 1);
        check_eq("t5 m1 c1 s_address", 32'(s_address), 32'h700);
        tick();
        tick();
        check_eq("t5 m1 c3 m1_ack", 32'(m1_acknowledge), 1);
        check_eq("t5 m1 c3 m1_read_data", m1_read_data, 32'h0BADF00D);
        m1_read = 1'b0;
        tick();

        // read=write=1 is a write
        slave_lat      = 1;
        m0_address     = 24'h000800;
        m0_byte_enable = 4'b0011;
        m0_write_data  = 32'h5A5A1234;
        m0_read        = 1'b1;
        m0_write       = 1'b1;
        tick();
        check_eq("t6 c1 s_write", 32'(s_write), 1);
        check_eq("t6 c1 s_read", 32'(s_read), 0);
        check_eq("t6 c1 s_byte_enable", 32'(s_byte_enable), 32'h3);
        check_eq("t6 c1 s_write_data", s_write_data, 32'h5A5A1234);
        acks = 0;
        for (int c = 1; c <= 6; c++) begin
            if (m0_acknowledge) acks++;
            if (c == 3) begin
                check_eq("t6 c3 m0_ack", 32'(m0_acknowledge), 1);
                m0_read  = 1'b0;
                m0_write = 1'b0;
            end
            tick();
        end
        check_eq("t6 ack count", 32'(acks), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255: slave wait-cycle limit before an aborted transfer, legal range 1..65535.
REQ-002 The block SHALL have parameter ERR_DATA, default 32'hDEADBEEF: read data returned on an aborted transfer.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, named clock and reset.
REQ-004 The block SHALL have these ports (mN = m0 = CPU, m1 = HPS bridge):
  clock  in  1  system clock, all logic rising-edge
  reset  in  1  asynchronous active-high reset
  mN_address  in  24  word/byte address from master N
  mN_byte_enable  in  4  byte lanes
  mN_read  in  1  read request, held until mN_acknowledge
  mN_write  in  1  write request, held until mN_acknowledge
  mN_write_data  in  32  write data
  mN_acknowledge  out  1  one-cycle completion pulse
  mN_read_data  out  32  read data, valid while mN_acknowledge=1
  s_address  out  24  to shared slave
  s_byte_enable  out  4  to shared slave
  s_read  out  1  to shared slave
  s_write  out  1  to shared slave
  s_write_data  out  32  to shared slave
  s_acknowledge  in  1  slave completion
  s_read_data  in  32  slave read data, valid with s_acknowledge
  grant  out  2  one-hot owner: 01=m0, 10=m1, 00=none
  timeout_error  out  1  sticky abort flag, cleared only by reset

Function
REQ-005 The block SHALL implement states IDLE, BUSY and RESP.
REQ-006 In IDLE, a master SHALL be requesting when its read or write input is 1; read=write=1 SHALL be treated as a write.
REQ-007 In IDLE with one requester, the block SHALL grant it; with both requesting, it SHALL grant the master not granted last (round-robin); after reset m0 SHALL have priority.
REQ-008 On grant, the block SHALL register the winner's address, byte_enable, write_data and read/write in the same edge and enter BUSY; s_* SHALL be driven from these registers only in BUSY.
REQ-009 First s_read/s_write assertion SHALL occur one cycle after the request is first seen in IDLE.
REQ-010 In BUSY, s_* SHALL remain stable until s_acknowledge=1; on s_acknowledge, the block SHALL capture s_read_data and enter RESP.
REQ-011 In RESP, the block SHALL drive the granted mN_acknowledge=1 for exactly one cycle with mN_read_data = captured data (writes: captured value, don't-care), then return to IDLE.
REQ-012 Master-side latency SHALL be: slave ack in cycle M gives master ack in cycle M+1; minimum request-to-ack latency 3 cycles with a zero-wait slave.
REQ-013 In IDLE after RESP, the block SHALL ignore the master just acknowledged for that one cycle, so a held request is not re-granted; the other master's pending request SHALL win.
REQ-014 A 16-bit wait counter SHALL clear on entering BUSY and increment each BUSY cycle without s_acknowledge.
REQ-015 When the wait counter reaches TIMEOUT, the block SHALL deassert s_read/s_write, set timeout_error, load ERR_DATA as read data and enter RESP.
REQ-016 s_acknowledge arriving in the same cycle the counter reaches TIMEOUT SHALL win: normal completion with slave data, no error.
REQ-017 s_acknowledge seen outside BUSY SHALL be ignored.
REQ-018 grant SHALL be 01/10 in BUSY and RESP, and 00 in IDLE.
REQ-019 Master request deassertion during BUSY (protocol violation) SHALL NOT abort the slave transfer; the acknowledge pulse SHALL still be issued.

Reset
REQ-020 On reset assertion, the block SHALL immediately enter IDLE, even mid-transfer, with the round-robin pointer favouring m0.
REQ-021 On reset, all outputs SHALL be 0, including s_read, s_write, mN_acknowledge, grant and timeout_error; wait counter and data registers SHALL also clear.
REQ-022 A slave transfer cut by reset SHALL NOT be completed or acknowledged after reset release.

Verification
REQ-023 Bench: m0 read 0x000100, zero-wait slave returns 0x12345678 -> s_read in cycle 1, m0_acknowledge in cycle 3 with 0x12345678, grant=01 in cycles 1-2.
REQ-024 Bench: m0 and m1 both write in the same cycle, held -> order m0, m1, m0, m1; each acknowledge exactly one cycle, no back-to-back grant to one master.
REQ-025 Bench: m1 read, slave never acks, TIMEOUT=4 -> s_read high 4 cycles, m1_acknowledge with 0xDEADBEEF, timeout_error=1 and sticky.
REQ-026 Bench: TIMEOUT=4, s_acknowledge in the 4th wait cycle with 0xCAFEF00D -> m1 receives 0xCAFEF00D, timeout_error stays 0.
REQ-027 Bench: reset pulsed during BUSY -> all outputs 0 the same cycle; no acknowledge after release; next m1 request granted normally.
REQ-028 Bench: m0 read=write=1, byte_enable=4'b0011 -> s_write=1, s_read=0, s_byte_enable=0011, single acknowledge.
